// File: rtl/plc_timer_pkg.sv
// Shared types for the PLC timer bank: channel mode encodings and channel FSM states.
package plc_timer_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF = 2'b00,
        MODE_MAN = 2'b01,
        MODE_TON = 2'b10,
        MODE_TP  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_TIMING  = 2'b01,
        ST_DONE    = 2'b10,
        ST_HOLDOFF = 2'b11
    } ch_state_t;

endpackage

// File: rtl/plc_timer_channel.sv
// One timer channel: start edge detector, tick counter and OFF/MAN/TON/TP state machine.
module plc_timer_channel
    import plc_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              tick,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic              estop,
    input  logic [CNT_W-1:0]  preset,
    output logic              ctrl,
    output logic              timing,
    output logic [CNT_W-1:0]  count
);

    ch_state_t        state;
    ch_state_t        state_nxt;
    mode_t            mode_cur;
    mode_t            mode_prev;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] count_inc;
    logic             ctrl_nxt;
    logic             start_prev;
    logic             rise;
    logic             done;

    assign mode_cur  = mode_t'(mode);
    assign rise      = start & ~start_prev;
    // Completion compares the registered count against the live preset.
    assign done      = (count >= preset);
    assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

    // State register; everything freezes while ena is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            ctrl       <= 1'b0;
            timing     <= 1'b0;
            start_prev <= 1'b0;
            mode_prev  <= MODE_OFF;
        end else if (ena) begin
            state      <= state_nxt;
            count      <= count_nxt;
            ctrl       <= ctrl_nxt;
            timing     <= (state_nxt == ST_TIMING);
            start_prev <= start;
            mode_prev  <= mode_cur;
        end
    end

    // Next-state logic: estop, then mode change, then per-mode behaviour.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        ctrl_nxt  = ctrl;

        if (estop || (mode_cur != mode_prev)) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
            ctrl_nxt  = 1'b0;
        end else begin
            case (mode_cur)
                MODE_MAN: begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                    ctrl_nxt  = start;
                end

                MODE_TON: begin
                    case (state)
                        ST_TIMING: begin
                            if (!start) begin
                                state_nxt = ST_IDLE;
                                count_nxt = '0;
                                ctrl_nxt  = 1'b0;
                            end else if (done) begin
                                state_nxt = ST_DONE;
                                ctrl_nxt  = 1'b1;
                            end else begin
                                ctrl_nxt = 1'b0;
                                if (tick) begin
                                    count_nxt = count_inc;
                                end
                            end
                        end
                        ST_DONE: begin
                            if (!start) begin
                                state_nxt = ST_IDLE;
                                count_nxt = '0;
                                ctrl_nxt  = 1'b0;
                            end else begin
                                ctrl_nxt = 1'b1;
                            end
                        end
                        default: begin
                            count_nxt = '0;
                            ctrl_nxt  = 1'b0;
                            state_nxt = rise ? ST_TIMING : ST_IDLE;
                        end
                    endcase
                end

                MODE_TP: begin
                    case (state)
                        ST_TIMING: begin
                            // Pulse runs to completion regardless of start; retrigger ignored.
                            ctrl_nxt = 1'b1;
                            if (done) begin
                                ctrl_nxt  = 1'b0;
                                count_nxt = '0;
                                state_nxt = start ? ST_HOLDOFF : ST_IDLE;
                            end else if (tick) begin
                                count_nxt = count_inc;
                            end
                        end
                        ST_HOLDOFF: begin
                            ctrl_nxt  = 1'b0;
                            count_nxt = '0;
                            if (!start) begin
                                state_nxt = ST_IDLE;
                            end
                        end
                        default: begin
                            count_nxt = '0;
                            ctrl_nxt  = rise;
                            state_nxt = rise ? ST_TIMING : ST_IDLE;
                        end
                    endcase
                end

                default: begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                    ctrl_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/plc_timer_bank.sv
// Multi-channel PLC timer bank: shared tick prescaler, preset register file,
// elapsed-count readback and E-stop capture around NUM_CH timer channels.
module plc_timer_bank
    import plc_timer_pkg::*;
#(
    parameter  int unsigned NUM_CH         = 4,
    parameter  int unsigned CNT_W          = 16,
    parameter  int unsigned TICK_DIV       = 50000,
    parameter  int unsigned DEFAULT_PRESET = 3000,
    localparam int unsigned CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ena,
    input  logic [NUM_CH-1:0]          start,
    input  logic [MODE_W*NUM_CH-1:0]   mode,
    input  logic                       estop,
    input  logic                       cfg_we,
    input  logic [CH_W-1:0]            cfg_ch,
    input  logic [CNT_W-1:0]           cfg_preset,
    output logic [NUM_CH-1:0]          ctrl,
    output logic [NUM_CH-1:0]          timing,
    output logic [CNT_W-1:0]           rd_elapsed,
    output logic                       estop_active
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] presets [NUM_CH];
    logic [CNT_W-1:0] counts  [NUM_CH];
    logic [CNT_W-1:0] rd_sel;

    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    // Free-running prescaler shared by every channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (ena) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    // Preset register file; indices at or above NUM_CH match no entry and are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                presets[i] <= CNT_W'(DEFAULT_PRESET);
            end
        end else if (ena && cfg_we) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (cfg_ch == CH_W'(i)) begin
                    presets[i] <= cfg_preset;
                end
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cfg_ch == CH_W'(i)) begin
                rd_sel = counts[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_elapsed   <= '0;
            estop_active <= 1'b0;
        end else if (ena) begin
            rd_elapsed   <= rd_sel;
            estop_active <= estop;
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        plc_timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .ena    (ena),
            .tick   (tick),
            .start  (start[g]),
            .mode   (mode[MODE_W*g +: MODE_W]),
            .estop  (estop),
            .preset (presets[g]),
            .ctrl   (ctrl[g]),
            .timing (timing[g]),
            .count  (counts[g])
        );
    end

endmodule

// File: tb/tb_plc_timer_bank.sv
// Self-checking bench for plc_timer_bank (TICK_DIV=1): scoreboard of expected outputs per clock edge.
module tb_plc_timer_bank;

    localparam logic [1:0] M_OFF = 2'b00;
    localparam logic [1:0] M_MAN = 2'b01;
    localparam logic [1:0] M_TON = 2'b10;
    localparam logic [1:0] M_TP  = 2'b11;

    logic        clk = 1'b0;
    logic        reset, ena, estop, cfg_we;
    logic [3:0]  start;
    logic [7:0]  mode;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_preset;
    logic [3:0]  ctrl, timing;
    logic [15:0] rd_elapsed;
    logic        estop_active;

    // Five-channel instance so that cfg_ch can address a non-existent channel.
    logic [4:0]  start5;
    logic [9:0]  mode5;
    logic        cfg_we5;
    logic [2:0]  cfg_ch5;
    logic [15:0] cfg_preset5;
    logic [4:0]  ctrl5, timing5;
    logic [15:0] rd5;
    logic        estop_active5;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    plc_timer_bank #(.NUM_CH(4), .CNT_W(16), .TICK_DIV(1), .DEFAULT_PRESET(3000)) dut (
        .clk(clk), .reset(reset), .ena(ena), .start(start), .mode(mode), .estop(estop),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_preset(cfg_preset), .ctrl(ctrl),
        .timing(timing), .rd_elapsed(rd_elapsed), .estop_active(estop_active)
    );

    plc_timer_bank #(.NUM_CH(5), .CNT_W(16), .TICK_DIV(1), .DEFAULT_PRESET(3000)) dut5 (
        .clk(clk), .reset(reset), .ena(ena), .start(start5), .mode(mode5), .estop(estop),
        .cfg_we(cfg_we5), .cfg_ch(cfg_ch5), .cfg_preset(cfg_preset5), .ctrl(ctrl5),
        .timing(timing5), .rd_elapsed(rd5), .estop_active(estop_active5)
    );

    typedef struct {
        string       name;
        logic [3:0]  cm;
        logic [3:0]  cv;
        logic [3:0]  tm;
        logic [3:0]  tv;
        bit          rc;
        logic [15:0] rv;
        bit          ec;
        logic        ev;
    } exp_t;

    typedef struct {
        logic [1:0] md;
        logic       st;
        logic       exp;
    } vec_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string n, input logic [3:0] cm, cv, tm, tv,
                              input bit rc, input logic [15:0] rv, input bit ec, input logic ev);
        exp_t e;
        e.name = n; e.cm = cm; e.cv = cv; e.tm = tm; e.tv = tv;
        e.rc = rc; e.rv = rv; e.ec = ec; e.ev = ev;
        sb.push_back(e);
    endtask

    task automatic expect_ct(input string n, input logic [3:0] cm, cv, tm, tv);
        expect_out(n, cm, cv, tm, tv, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock, then compare everything queued for this edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.cm != 4'h0) check({e.name, " ctrl"}, 32'(ctrl & e.cm), 32'(e.cv & e.cm));
            if (e.tm != 4'h0) check({e.name, " timing"}, 32'(timing & e.tm), 32'(e.tv & e.tm));
            if (e.rc) check({e.name, " rd_elapsed"}, 32'(rd_elapsed), 32'(e.rv));
            if (e.ec) check({e.name, " estop_active"}, 32'(estop_active), 32'(e.ev));
        end
    endtask

    task automatic write_preset(input logic [1:0] ch, input logic [15:0] val);
        cfg_we = 1'b1; cfg_ch = ch; cfg_preset = val;
        step();
        cfg_we = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [12];

        reset = 1'b1; ena = 1'b1; estop = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_preset = 16'd0;
        start = 4'h0; mode = 8'h00;
        start5 = 5'h0; mode5 = {8'h00, M_TON}; cfg_we5 = 1'b0; cfg_ch5 = 3'd0; cfg_preset5 = 16'd0;

        // Reset state, with estop asserted to show reset dominates.
        expect_out("reset", 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 16'd0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 4; i++) check($sformatf("reset preset%0d", i), 32'(dut.presets[i]), 32'd3000);
        reset = 1'b0; estop = 1'b0;
        step();

        // TON, preset 20, start held.
        mode[1:0] = M_TON;
        write_preset(2'd0, 16'd20);
        start[0] = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            expect_out($sformatf("ton20 k%0d", k), 4'h1, {3'b0, k == 21}, 4'h1, {3'b0, k < 21},
                       1'b1, (k == 0) ? 16'd0 : 16'(k - 1), 1'b0, 1'b0);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            expect_out("ton20 hold", 4'h1, 4'h1, 4'h1, 4'h0, 1'b1, 16'd20, 1'b0, 1'b0);
            step();
        end
        start[0] = 1'b0;
        expect_out("ton20 release", 4'h1, 4'h0, 4'h1, 4'h0, 1'b1, 16'd20, 1'b0, 1'b0);
        step();
        expect_out("ton20 cleared", 4'h1, 4'h0, 4'h1, 4'h0, 1'b1, 16'd0, 1'b0, 1'b0);
        step();

        // TP, preset 5: one-cycle start, retrigger mid-pulse at k=3.
        mode[3:2] = M_TP;
        write_preset(2'd1, 16'd5);
        for (int k = 0; k <= 8; k++) begin
            start[1] = (k == 0 || k == 3);
            expect_ct($sformatf("tp5 pulse k%0d", k), 4'h2, {2'b0, k <= 5, 1'b0}, 4'h2, {2'b0, k <= 5, 1'b0});
            step();
        end
        start[1] = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            expect_ct($sformatf("tp5 held k%0d", k), 4'h2, {2'b0, k <= 5, 1'b0}, 4'h2, {2'b0, k <= 5, 1'b0});
            step();
        end
        start[1] = 1'b0;
        expect_ct("tp5 holdoff exit", 4'h2, 4'h0, 4'h2, 4'h0);
        step();
        start[1] = 1'b1;
        expect_ct("tp5 rearm", 4'h2, 4'h2, 4'h2, 4'h2);
        step();
        start[1] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            expect_ct($sformatf("tp5 rearm k%0d", k), 4'h2, {2'b0, k <= 5, 1'b0}, 4'h0, 4'h0);
            step();
        end

        // MAN then OFF on ch2, table driven; first row of each mode is the mode-change cycle.
        tbl[0]  = '{M_MAN, 1'b1, 1'b0};
        tbl[1]  = '{M_MAN, 1'b1, 1'b1};
        tbl[2]  = '{M_MAN, 1'b0, 1'b0};
        tbl[3]  = '{M_MAN, 1'b1, 1'b1};
        tbl[4]  = '{M_MAN, 1'b0, 1'b0};
        tbl[5]  = '{M_MAN, 1'b0, 1'b0};
        tbl[6]  = '{M_MAN, 1'b1, 1'b1};
        tbl[7]  = '{M_OFF, 1'b1, 1'b0};
        tbl[8]  = '{M_OFF, 1'b0, 1'b0};
        tbl[9]  = '{M_OFF, 1'b1, 1'b0};
        tbl[10] = '{M_OFF, 1'b1, 1'b0};
        tbl[11] = '{M_OFF, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            mode[5:4] = tbl[i].md;
            start[2]  = tbl[i].st;
            expect_ct($sformatf("man/off row%0d", i), 4'h4, {1'b0, tbl[i].exp, 2'b0}, 4'h4, 4'h0);
            step();
        end

        // All channels active, then estop.
        mode = {M_TON, M_MAN, M_TP, M_TON};
        start = 4'h0;
        write_preset(2'd1, 16'd50);
        start = 4'hF;
        for (int k = 0; k < 24; k++) step();
        expect_ct("all active", 4'hF, 4'b0111, 4'hF, 4'b1010);
        step();
        estop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_out($sformatf("estop k%0d", k), 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 16'd0, 1'b1, 1'b1);
            step();
        end
        estop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_out($sformatf("estop release k%0d", k), 4'hF, 4'b0100, 4'hF, 4'h0, 1'b0, 16'd0, 1'b1, 1'b0);
            step();
        end
        start = 4'h0;
        expect_ct("estop start low", 4'hF, 4'h0, 4'hF, 4'h0);
        step();
        start = 4'hF;
        expect_ct("estop fresh rise", 4'hF, 4'b0110, 4'hF, 4'b1011);
        step();
        start = 4'h0;
        expect_ct("tp no truncate", 4'hF, 4'b0010, 4'hF, 4'b0010);
        step();
        mode = 8'h00;
        expect_ct("all off", 4'hF, 4'h0, 4'hF, 4'h0);
        step();

        // Preset rewrite below the running count completes on the next edge.
        mode[1:0] = M_TON;
        cfg_ch = 2'd0;
        step();
        step();
        start[0] = 1'b1;
        for (int k = 0; k <= 10; k++) step();
        cfg_we = 1'b1; cfg_preset = 16'd4;
        expect_out("preset write", 4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 16'd10, 1'b0, 1'b0);
        step();
        cfg_we = 1'b0;
        expect_out("early done", 4'h1, 4'h1, 4'h1, 4'h0, 1'b1, 16'd11, 1'b0, 1'b0);
        step();

        // ena low freezes count, readback and completion.
        start[0] = 1'b0;
        step();
        start[0] = 1'b1;
        step();
        step();
        step();
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_out($sformatf("freeze k%0d", k), 4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 16'd1, 1'b0, 1'b0);
            step();
        end
        ena = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            expect_out($sformatf("resume k%0d", k), 4'h1, {3'b0, k == 5}, 4'h1, {3'b0, k < 5},
                       1'b1, 16'(k - 1), 1'b0, 1'b0);
            step();
        end

        // Mode change mid-TIMING forces IDLE; a fresh rise is needed.
        start[0] = 1'b0;
        step();
        start[0] = 1'b1;
        step();
        step();
        mode[1:0] = M_TP;
        expect_ct("mode change", 4'h1, 4'h0, 4'h1, 4'h0);
        step();
        for (int k = 0; k < 2; k++) begin
            expect_ct("mode change no rise", 4'h1, 4'h0, 4'h1, 4'h0);
            step();
        end
        start[0] = 1'b0;
        step();
        start[0] = 1'b1;
        expect_ct("mode change restart", 4'h1, 4'h1, 4'h1, 4'h1);
        step();
        start[0] = 1'b0;
        mode[1:0] = M_OFF;
        step();

        // Preset 0 boundary on ch3: one-cycle TON delay and one-cycle TP pulse.
        mode[7:6] = M_TON;
        write_preset(2'd3, 16'd0);
        start[3] = 1'b1;
        expect_ct("ton p0 k0", 4'h8, 4'h0, 4'h8, 4'h8);
        step();
        expect_ct("ton p0 k1", 4'h8, 4'h8, 4'h8, 4'h0);
        step();
        start[3] = 1'b0;
        mode[7:6] = M_TP;
        step();
        step();
        start[3] = 1'b1;
        expect_ct("tp p0 k0", 4'h8, 4'h8, 4'h8, 4'h8);
        step();
        expect_ct("tp p0 k1", 4'h8, 4'h0, 4'h8, 4'h0);
        step();
        start[3] = 1'b0;
        step();

        // Out-of-range config index on the five-channel instance.
        start5[0] = 1'b1;
        for (int k = 0; k <= 4; k++) step();
        check("dut5 rd ch0", 32'(rd5), 32'd3);
        cfg_ch5 = 3'd7; cfg_we5 = 1'b1; cfg_preset5 = 16'd0;
        step();
        cfg_we5 = 1'b0;
        check("dut5 rd oor", 32'(rd5), 32'd0);
        for (int i = 0; i < 5; i++) check($sformatf("dut5 preset%0d kept", i), 32'(dut5.presets[i]), 32'd3000);
        step();
        check("dut5 ctrl unaffected", 32'(ctrl5), 32'd0);
        cfg_ch5 = 3'd4; cfg_we5 = 1'b1; cfg_preset5 = 16'd9;
        step();
        cfg_we5 = 1'b0;
        check("dut5 preset4 written", 32'(dut5.presets[4]), 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
